dmem_arbiter: RTL and testbench

- Two-port arbiter and access sequencer for the 8-bit core's data memory.
- Shares the single data memory port between the processor load/store path (port A) and a debug/program loader (port B).
- Grants one requester at a time, round-robin on contention.
- Runs a fixed-length multi-cycle access, then returns read data with a one-cycle acknowledge.

---
 rtl/dmem_arbiter_if.sv | 44 ++++
 rtl/dmem_arbiter.sv | 109 ++++++++++
 tb/tb_dmem_arbiter.sv | 341 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the two requesters, the data memory and dmem_arbiter.
// The slave modport is the arbiter's view; master is the requester/memory side.
interface dmem_arbiter_if #(
    parameter int unsigned AW = 8,
    parameter int unsigned DW = 8
) ();
    logic          a_req;
    logic          a_we;
    logic [AW-1:0] a_addr;
    logic [DW-1:0] a_wdata;
    logic [DW-1:0] a_rdata;
    logic          a_ack;

    logic          b_req;
    logic          b_we;
    logic [AW-1:0] b_addr;
    logic [DW-1:0] b_wdata;
    logic [DW-1:0] b_rdata;
    logic          b_ack;

    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_we;
    logic [DW-1:0] mem_rdata;

    logic          busy;
    logic          grant_b;

    modport slave (
        input  a_req, a_we, a_addr, a_wdata,
        input  b_req, b_we, b_addr, b_wdata,
        input  mem_rdata,
        output a_rdata, a_ack, b_rdata, b_ack,
        output mem_addr, mem_wdata, mem_we, busy, grant_b
    );

    modport master (
        output a_req, a_we, a_addr, a_wdata,
        output b_req, b_we, b_addr, b_wdata,
        output mem_rdata,
        input  a_rdata, a_ack, b_rdata, b_ack,
        input  mem_addr, mem_wdata, mem_we, busy, grant_b
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter and fixed-length access sequencer for the data memory.
// Each access: latch request, hold it ACC_CYCLES at the memory, then a one-cycle ack.
module dmem_arbiter #(
    parameter int unsigned AW         = 8,
    parameter int unsigned DW         = 8,
    parameter int unsigned ACC_CYCLES = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    dmem_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

    localparam logic [3:0] CntLoad = 4'(ACC_CYCLES - 1);

    state_e        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          last_b_q, last_b_d;
    logic          grant_b_q, grant_b_d;
    logic          we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [DW-1:0] a_rdata_q, a_rdata_d;
    logic [DW-1:0] b_rdata_q, b_rdata_d;
    logic          strobe;
    logic          pick_b;

    assign strobe = (state_q == StAccess) && (cnt_q == 4'd0);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        last_b_d  = last_b_q;
        grant_b_d = grant_b_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        a_rdata_d = a_rdata_q;
        b_rdata_d = b_rdata_q;
        // On a tie, B wins only if A was served last.
        pick_b    = bus.b_req && (!bus.a_req || !last_b_q);
        case (state_q)
            StIdle: begin
                if (bus.a_req || bus.b_req) begin
                    grant_b_d = pick_b;
                    last_b_d  = pick_b;
                    we_d      = pick_b ? bus.b_we    : bus.a_we;
                    addr_d    = pick_b ? bus.b_addr  : bus.a_addr;
                    wdata_d   = pick_b ? bus.b_wdata : bus.a_wdata;
                    cnt_d     = CntLoad;
                    state_d   = StAccess;
                end
            end
            StAccess: begin
                if (cnt_q == 4'd0) begin
                    if (grant_b_q) begin
                        b_rdata_d = bus.mem_rdata;
                    end else begin
                        a_rdata_d = bus.mem_rdata;
                    end
                    state_d = StResp;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            cnt_q     <= 4'd0;
            last_b_q  <= 1'b1;
            grant_b_q <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            a_rdata_q <= '0;
            b_rdata_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            last_b_q  <= last_b_d;
            grant_b_q <= grant_b_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            a_rdata_q <= a_rdata_d;
            b_rdata_q <= b_rdata_d;
        end
    end

    // Outputs decode from registered state so reset drops them without waiting for a clock.
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.mem_we    = strobe && we_q;
    assign bus.busy      = (state_q != StIdle);
    assign bus.grant_b   = grant_b_q;
    assign bus.a_ack     = (state_q == StResp) && !grant_b_q;
    assign bus.b_ack     = (state_q == StResp) && grant_b_q;
    assign bus.a_rdata   = a_rdata_q;
    assign bus.b_rdata   = b_rdata_q;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: an ACC_CYCLES=2 instance for the main scenarios and
// an ACC_CYCLES=1 instance for the reset-during-access scenario.
module tb_dmem_arbiter;
    logic clk;
    logic rst0_n;
    logic rst1_n;
    int   total;
    int   bad;

    logic       pl_we;
    logic [7:0] pl_addr;
    logic [7:0] pl_data;
    logic [7:0] mem0 [256];
    logic [7:0] mem1 [256];

    dmem_arbiter_if #(.AW(8), .DW(8)) bus0 ();
    dmem_arbiter_if #(.AW(8), .DW(8)) bus1 ();

    dmem_arbiter #(.AW(8), .DW(8), .ACC_CYCLES(2)) u_dut0 (
        .clk   (clk),
        .rst_n (rst0_n),
        .bus   (bus0)
    );

    dmem_arbiter #(.AW(8), .DW(8), .ACC_CYCLES(1)) u_dut1 (
        .clk   (clk),
        .rst_n (rst1_n),
        .bus   (bus1)
    );

    // {busy, grant_b, mem_we, a_ack, b_ack}
    logic [4:0] ctl0;
    logic [4:0] ctl1;
    assign ctl0 = {bus0.busy, bus0.grant_b, bus0.mem_we, bus0.a_ack, bus0.b_ack};
    assign ctl1 = {bus1.busy, bus1.grant_b, bus1.mem_we, bus1.a_ack, bus1.b_ack};

    assign bus0.mem_rdata = mem0[bus0.mem_addr];
    assign bus1.mem_rdata = mem1[bus1.mem_addr];

    always @(posedge clk) begin
        if (bus0.mem_we) mem0[bus0.mem_addr] <= bus0.mem_wdata;
        else if (pl_we) mem0[pl_addr] <= pl_data;
        if (bus1.mem_we) mem1[bus1.mem_addr] <= bus1.mem_wdata;
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst0_n = 1'b0;
        rst1_n = 1'b0;
        bus0.a_req = 1'b1;
        bus0.b_req = 1'b1;
        pl_we = 1'b1;
        pl_addr = 8'h10;
        pl_data = 8'h5A;
        repeat (3) step();
        pl_we = 1'b0;
        @(negedge clk);
        total++;
        if (ctl0 !== 5'b00000) begin
            bad++; $display("FAIL reset_ctl got=%b exp=00000", ctl0);
        end
        total++;
        if ({bus0.mem_addr, bus0.mem_wdata} !== 16'h0000) begin
            bad++; $display("FAIL reset_mem_bus got=%h exp=0000", {bus0.mem_addr, bus0.mem_wdata});
        end
        total++;
        if ({bus0.a_rdata, bus0.b_rdata} !== 16'h0000) begin
            bad++; $display("FAIL reset_rdata got=%h exp=0000", {bus0.a_rdata, bus0.b_rdata});
        end
        step();
        rst0_n = 1'b1;
        rst1_n = 1'b1;
        step();
        bus0.a_req = 1'b0;
        bus0.b_req = 1'b0;
        @(negedge clk);
        total++;
        if (ctl0 !== 5'b10000) begin
            bad++; $display("FAIL reset_first_grant got=%b exp=10000", ctl0);
        end
        repeat (2) step();
        @(negedge clk);
        total++;
        if (ctl0 !== 5'b10010) begin
            bad++; $display("FAIL reset_first_ack got=%b exp=10010", ctl0);
        end
        step();
    endtask

    task automatic test_single_read;
        bus0.a_req = 1'b1;
        bus0.a_we = 1'b0;
        bus0.a_addr = 8'h10;
        step();
        @(negedge clk);
        total++;
        if ({ctl0, bus0.mem_addr} !== {5'b10000, 8'h10}) begin
            bad++; $display("FAIL read_c1 got=%b/%h exp=10000/10", ctl0, bus0.mem_addr);
        end
        step();
        @(negedge clk);
        total++;
        if ({ctl0, bus0.mem_addr} !== {5'b10000, 8'h10}) begin
            bad++; $display("FAIL read_c2 got=%b/%h exp=10000/10", ctl0, bus0.mem_addr);
        end
        step();
        @(negedge clk);
        total++;
        if ({ctl0, bus0.a_rdata} !== {5'b10010, 8'h5A}) begin
            bad++; $display("FAIL read_c3 got=%b/%h exp=10010/5a", ctl0, bus0.a_rdata);
        end
        step();
        bus0.a_req = 1'b0;
        @(negedge clk);
        total++;
        if (ctl0 !== 5'b00000) begin
            bad++; $display("FAIL read_c4 got=%b exp=00000", ctl0);
        end
        step();
    endtask

    task automatic test_single_write;
        bus0.b_req = 1'b1;
        bus0.b_we = 1'b1;
        bus0.b_addr = 8'h22;
        bus0.b_wdata = 8'hC3;
        step();
        @(negedge clk);
        total++;
        if ({ctl0, bus0.mem_addr} !== {5'b11000, 8'h22}) begin
            bad++; $display("FAIL write_c1 got=%b/%h exp=11000/22", ctl0, bus0.mem_addr);
        end
        step();
        @(negedge clk);
        total++;
        if ({ctl0, bus0.mem_addr, bus0.mem_wdata} !== {5'b11100, 8'h22, 8'hC3}) begin
            bad++; $display("FAIL write_strobe got=%b/%h/%h exp=11100/22/c3",
                            ctl0, bus0.mem_addr, bus0.mem_wdata);
        end
        step();
        @(negedge clk);
        total++;
        if (ctl0 !== 5'b11001) begin
            bad++; $display("FAIL write_ack got=%b exp=11001", ctl0);
        end
        step();
        bus0.b_req = 1'b0;
        bus0.b_we = 1'b0;
        @(negedge clk);
        total++;
        if (ctl0 !== 5'b01000) begin
            bad++; $display("FAIL write_idle got=%b exp=01000", ctl0);
        end
        total++;
        if (mem0[8'h22] !== 8'hC3) begin
            bad++; $display("FAIL write_mem got=%h exp=c3", mem0[8'h22]);
        end
        step();
    endtask

    task automatic test_fairness;
        logic       g;
        logic [4:0] exp_ctl;
        bus0.a_req = 1'b1;
        bus0.a_we = 1'b0;
        bus0.a_addr = 8'h10;
        bus0.b_req = 1'b1;
        bus0.b_we = 1'b0;
        bus0.b_addr = 8'h22;
        for (int k = 0; k < 6; k++) begin
            g = k[0];
            step();
            @(negedge clk);
            exp_ctl = {1'b1, g, 3'b000};
            total++;
            if (ctl0 !== exp_ctl) begin
                bad++; $display("FAIL fair_grant%0d got=%b exp=%b", k, ctl0, exp_ctl);
            end
            repeat (2) step();
            @(negedge clk);
            exp_ctl = {1'b1, g, 1'b0, !g, g};
            total++;
            if (ctl0 !== exp_ctl) begin
                bad++; $display("FAIL fair_ack%0d got=%b exp=%b", k, ctl0, exp_ctl);
            end
            total++;
            if ((g ? bus0.b_rdata : bus0.a_rdata) !== (g ? 8'hC3 : 8'h5A)) begin
                bad++; $display("FAIL fair_rdata%0d got=%h/%h", k, bus0.a_rdata, bus0.b_rdata);
            end
            step();
            if (k == 5) begin
                bus0.a_req = 1'b0;
                bus0.b_req = 1'b0;
            end
            @(negedge clk);
            exp_ctl = {1'b0, g, 3'b000};
            total++;
            if (ctl0 !== exp_ctl) begin
                bad++; $display("FAIL fair_gap%0d got=%b exp=%b", k, ctl0, exp_ctl);
            end
        end
        step();
    endtask

    task automatic test_write_readback;
        bus0.a_req = 1'b1;
        bus0.a_we = 1'b0;
        bus0.a_addr = 8'h22;
        repeat (3) step();
        @(negedge clk);
        total++;
        if ({ctl0, bus0.a_rdata} !== {5'b10010, 8'hC3}) begin
            bad++; $display("FAIL readback got=%b/%h exp=10010/c3", ctl0, bus0.a_rdata);
        end
        step();
        bus0.a_req = 1'b0;
        step();
    endtask

    task automatic test_mid_access;
        bus0.a_req = 1'b1;
        bus0.a_we = 1'b0;
        bus0.a_addr = 8'h10;
        step();
        bus0.a_addr = 8'h77;
        bus0.a_req = 1'b0;
        @(negedge clk);
        total++;
        if ({ctl0, bus0.mem_addr} !== {5'b10000, 8'h10}) begin
            bad++; $display("FAIL mid_c1 got=%b/%h exp=10000/10", ctl0, bus0.mem_addr);
        end
        step();
        @(negedge clk);
        total++;
        if (bus0.mem_addr !== 8'h10) begin
            bad++; $display("FAIL mid_c2_addr got=%h exp=10", bus0.mem_addr);
        end
        step();
        @(negedge clk);
        total++;
        if ({ctl0, bus0.a_rdata} !== {5'b10010, 8'h5A}) begin
            bad++; $display("FAIL mid_ack got=%b/%h exp=10010/5a", ctl0, bus0.a_rdata);
        end
        step();
        @(negedge clk);
        total++;
        if ({ctl0, bus0.mem_addr} !== {5'b00000, 8'h10}) begin
            bad++; $display("FAIL mid_hold got=%b/%h exp=00000/10", ctl0, bus0.mem_addr);
        end
        step();
    endtask

    task automatic test_reset_midop;
        bus1.a_req = 1'b1;
        bus1.a_we = 1'b1;
        bus1.a_addr = 8'h30;
        bus1.a_wdata = 8'h11;
        step();
        @(negedge clk);
        total++;
        if (ctl1 !== 5'b10100) begin
            bad++; $display("FAIL rmid_strobe got=%b exp=10100", ctl1);
        end
        #1 rst1_n = 1'b0;
        #1;
        total++;
        if (ctl1 !== 5'b00000) begin
            bad++; $display("FAIL rmid_async got=%b exp=00000", ctl1);
        end
        bus1.a_req = 1'b0;
        repeat (2) step();
        rst1_n = 1'b1;
        bus1.a_req = 1'b1;
        bus1.a_we = 1'b1;
        bus1.a_addr = 8'h31;
        bus1.a_wdata = 8'h44;
        @(negedge clk);
        total++;
        if (ctl1 !== 5'b00000) begin
            bad++; $display("FAIL rmid_c0 got=%b exp=00000", ctl1);
        end
        step();
        @(negedge clk);
        total++;
        if ({ctl1, bus1.mem_addr, bus1.mem_wdata} !== {5'b10100, 8'h31, 8'h44}) begin
            bad++; $display("FAIL rmid_c1 got=%b/%h/%h exp=10100/31/44",
                            ctl1, bus1.mem_addr, bus1.mem_wdata);
        end
        step();
        @(negedge clk);
        total++;
        if (ctl1 !== 5'b10010) begin
            bad++; $display("FAIL rmid_ack got=%b exp=10010", ctl1);
        end
        step();
        bus1.a_req = 1'b0;
        @(negedge clk);
        total++;
        if ((ctl1 !== 5'b00000) || (mem1[8'h31] !== 8'h44)) begin
            bad++; $display("FAIL rmid_done got=%b/%h exp=00000/44", ctl1, mem1[8'h31]);
        end
    endtask

    initial begin
        total = 0;
        bad = 0;
        rst0_n = 1'b0;
        rst1_n = 1'b0;
        pl_we = 1'b0;
        pl_addr = 8'h00;
        pl_data = 8'h00;
        bus0.a_req = 1'b0; bus0.a_we = 1'b0; bus0.a_addr = 8'h00; bus0.a_wdata = 8'h00;
        bus0.b_req = 1'b0; bus0.b_we = 1'b0; bus0.b_addr = 8'h00; bus0.b_wdata = 8'h00;
        bus1.a_req = 1'b0; bus1.a_we = 1'b0; bus1.a_addr = 8'h00; bus1.a_wdata = 8'h00;
        bus1.b_req = 1'b0; bus1.b_we = 1'b0; bus1.b_addr = 8'h00; bus1.b_wdata = 8'h00;
        test_reset();
        test_single_read();
        test_single_write();
        test_fairness();
        test_write_readback();
        test_mid_access();
        test_reset_midop();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
